// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU among NUM_REQ requesters
//
// Purpose: accepts one operation at a time from NUM_REQ requesters (round-robin),
// drives it to an external shared ALU, captures the ALU outputs one cycle later and
// returns them on a valid/ready response channel tagged with the requester id.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    per-requester request handshake (req_ready one-hot or zero)
//   req_a, req_b, req_op     packed operands (32b each) and ALU control codes (4b each)
//   alu_a, alu_b, alu_ctrl   registered operands/control to the shared ALU
//   alu_result, alu_zero,
//   alu_carry, alu_ovf       combinational ALU outputs
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_result,
//   rsp_flags                response payload, flags = {err, ovf, carry, zero}
//   busy                     high whenever the FSM is not IDLE
//
// Configuration: define ALU_ARBITER_OPCHECK_EN to replace the result of any
// unsupported opcode with rsp_result=0, rsp_flags=4'b1000.

module alu_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    input  logic [NUM_REQ*4-1:0]   req_op,
    output logic [31:0]            alu_a,
    output logic [31:0]            alu_b,
    output logic [3:0]             alu_ctrl,
    input  logic [31:0]            alu_result,
    input  logic                   alu_zero,
    input  logic                   alu_carry,
    input  logic                   alu_ovf,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2:0]             rsp_id,
    output logic [31:0]            rsp_result,
    output logic [3:0]             rsp_flags,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  id_q, id_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;

    logic [7:0]  valid_ext;
    logic [3:0]  cand;
    logic        grant_found;
    logic [2:0]  grant_idx;
    logic        accept;
    logic [31:0] sel_a, sel_b;
    logic [3:0]  sel_op;
    logic        op_illegal;

    // Widened so the rotating candidate index can address it at full 3-bit width.
    assign valid_ext = 8'(req_valid);

    // Round-robin search: first valid index at or above ptr, wrapping past NUM_REQ-1.
    always_comb begin
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!grant_found && valid_ext[cand[2:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[2:0];
            end
        end
    end

    // Accept is independent of rst so no flop D-input depends on the async reset net;
    // the reset gating is applied only on the req_ready output.
    assign accept = (state_q == IDLE) && grant_found;

    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = accept && !rst && (grant_idx == 3'(j));
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == 3'(j)) begin
                sel_a  = req_a[32*j +: 32];
                sel_b  = req_b[32*j +: 32];
                sel_op = req_op[4*j +: 4];
            end
        end
    end

`ifdef ALU_ARBITER_OPCHECK_EN
    always_comb begin
        op_illegal = !(alu_ctrl_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                          4'b0101, 4'b0110, 4'b0111});
    end
`else
    always_comb begin
        op_illegal = 1'b0;
    end
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    // Datapath next-state: operands latch on accept, results latch in EXEC.
    always_comb begin
        ptr_d        = ptr_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        if (accept) begin
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            alu_ctrl_d = sel_op;
            id_d       = grant_idx;
            ptr_d      = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
        if (state_q == EXEC) begin
            if (op_illegal) begin
                rsp_result_d = '0;
                rsp_flags_d  = 4'b1000;
            end else begin
                rsp_result_d = alu_result;
                rsp_flags_d  = {1'b0, alu_ovf, alu_carry, alu_zero};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            id_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_id     = id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard testbench for alu_arbiter with a behavioural shared ALU

module tb_alu_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*32-1:0]  req_a = '0;
    logic [N*32-1:0]  req_b = '0;
    logic [N*4-1:0]   req_op = '0;
    logic [31:0]      alu_a, alu_b;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_result;
    logic             alu_zero, alu_carry, alu_ovf;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [2:0]       rsp_id;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic             busy;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    // Behavioural ALU: returns {ovf, carry, zero, result}.
    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                           v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0001: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0010: r = a & b;
            4'b0100: r = a | b;
            4'b0101: r = a ^ b;
            4'b0110: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0111: r = a << b[4:0];
            default: r = 32'hDEADBEEF;
        endcase
        return {v, c, (r == 32'd0), r};
    endfunction

    logic [34:0] alu_out;
    assign alu_out    = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_result = alu_out[31:0];
    assign alu_zero   = alu_out[32];
    assign alu_carry  = alu_out[33];
    assign alu_ovf    = alu_out[34];

    // Expected response {flags, result} for a request, from the arbiter's rules.
    function automatic logic [35:0] exp_rsp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [34:0] o;
        logic        legal;
        legal = (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0100) ||
                (op == 4'b0101) || (op == 4'b0110) || (op == 4'b0111);
`ifdef ALU_ARBITER_OPCHECK_EN
        if (!legal) return {4'b1000, 32'd0};
`else
        if (!legal) legal = 1'b0;
`endif
        o = alu_fn(a, b, op);
        return {1'b0, o[34], o[33], o[32], o[31:0]};
    endfunction

    function automatic int rr_pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [2:0]  id;
        logic [31:0] res;
        logic [3:0]  fl;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          mptr = 0;
    int          step_grant = -1;
    int          grant_log[$];
    logic [N-1:0] pend_v = '0;
    logic [31:0] pend_a[N];
    logic [31:0] pend_b[N];
    logic [3:0]  pend_op[N];
    logic        rdy_drv = 1'b1;
    logic [2:0]  last_id = '0;
    logic [31:0] last_res = '0;
    logic [3:0]  last_fl = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // One cycle of stimulus plus the request-side model check.
    task automatic step();
        logic [N-1:0] exp_ready;
        logic [35:0]  e;
        int           g;
        exp_t         ent;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend_v[i];
            req_a[32*i +: 32]   = pend_a[i];
            req_b[32*i +: 32]   = pend_b[i];
            req_op[4*i +: 4]    = pend_op[i];
        end
        rsp_ready = rdy_drv;
        #1;
        exp_ready  = '0;
        step_grant = -1;
        chk("busy", 64'(busy), 64'(acc_cnt != done_cnt));
        if (!rst && acc_cnt == done_cnt && |req_valid) begin
            g = rr_pick(mptr, req_valid);
            exp_ready[g] = 1'b1;
            e = exp_rsp(pend_a[g], pend_b[g], pend_op[g]);
            ent.id  = 3'(g);
            ent.res = e[31:0];
            ent.fl  = e[35:32];
            ent.cyc = cyc + 2;
            sb.push_back(ent);
            acc_cnt++;
            mptr = (g + 1) % N;
            pend_v[g] = 1'b0;
            step_grant = g;
            grant_log.push_back(g);
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((acc_cnt != done_cnt || |pend_v) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("wait_idle_timeout", 64'(1), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        acc_cnt = done_cnt;
        mptr = 0;
        req_valid = '1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_result", 64'(rsp_result), 64'(0));
        chk("rst_rsp_flags", 64'(rsp_flags), 64'(0));
        chk("rst_alu_a", 64'(alu_a), 64'(0));
        chk("rst_alu_b", 64'(alu_b), 64'(0));
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        pend_v = '0;
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        pend_v[i]  = 1'b1;
        pend_a[i]  = a;
        pend_b[i]  = b;
        pend_op[i] = op;
    endtask

    // Response monitor: every presented response must match the oldest expectation.
    initial begin
        logic prev_rv;
        exp_t e;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_rv = 1'b0;
            end else begin
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                    end else begin
                        e = sb[0];
                        if (!prev_rv) chk("latency", 64'(cyc), 64'(e.cyc));
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_result", 64'(rsp_result), 64'(e.res));
                        chk("rsp_flags", 64'(rsp_flags), 64'(e.fl));
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            last_id  = rsp_id;
                            last_res = rsp_result;
                            last_fl  = rsp_flags;
                            done_cnt++;
                        end
                    end
                end
                prev_rv = rsp_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] legal_ops[7];
        int         exp_order[5];
        int         t;
        legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            pend_a[i] = '0; pend_b[i] = '0; pend_op[i] = '0;
        end
        do_reset();

        // Single add from requester 0.
        set_req(0, 32'd5, 32'd3, 4'b0000);
        step();
        chk("first_grant", 64'(req_ready), 64'(4'b0001));
        wait_idle();
        chk("add_id", 64'(last_id), 64'(0));
        chk("add_res", 64'(last_res), 64'(8));
        chk("add_fl", 64'(last_fl), 64'(0));

        // All requesters continuously valid: round-robin order.
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) set_req(i, 32'd7, 32'd7, 4'b0001);
        t = 0;
        while (grant_log.size() < 5 && t < 60) begin
            step();
            if (step_grant >= 0) pend_v[step_grant] = 1'b1;
            t++;
        end
        pend_v = '0;
        wait_idle();
        chk("rr_count", 64'(grant_log.size()), 64'(5));
        for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_order", 64'(grant_log[k]), 64'(exp_order[k]));
        chk("sub_res", 64'(last_res), 64'(0));
        chk("sub_zero", 64'(last_fl[0]), 64'(1));

        // Carry/zero from all-ones + 1 on requester 2.
        set_req(2, 32'hFFFFFFFF, 32'd1, 4'b0000);
        wait_idle();
        chk("carry_id", 64'(last_id), 64'(2));
        chk("carry_res", 64'(last_res), 64'(0));
        chk("carry_fl", 64'(last_fl), 64'(4'b0011));

        // Response back-pressure for 5 cycles.
        rdy_drv = 1'b0;
        set_req(3, 32'd10, 32'd20, 4'b0000);
        t = 0;
        while (!rsp_valid && t < 20) begin step(); t++; end
        chk("stall_reached", 64'(rsp_valid), 64'(1));
        set_req(0, 32'd1, 32'd2, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", 64'(rsp_valid), 64'(1));
            chk("stall_busy", 64'(busy), 64'(1));
            chk("stall_result", 64'(rsp_result), 64'(30));
        end
        rdy_drv = 1'b1;
        wait_idle();

        // Reset during EXEC abandons the operation.
        set_req(1, 32'd4, 32'd4, 4'b0000);
        step();
        chk("pre_rst_grant", 64'(req_ready), 64'(4'b0010));
        do_reset();
        repeat (4) begin
            step();
            chk("no_rsp_after_rst", 64'(rsp_valid), 64'(0));
        end
        set_req(1, 32'd1, 32'd1, 4'b0000);
        set_req(2, 32'd2, 32'd2, 4'b0000);
        step();
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0010));
        wait_idle();

        // Unsupported opcode.
        set_req(0, 32'd1, 32'd1, 4'b1111);
        wait_idle();
`ifdef ALU_ARBITER_OPCHECK_EN
        chk("illegal_res", 64'(last_res), 64'(0));
        chk("illegal_fl", 64'(last_fl), 64'(4'b1000));
`else
        chk("illegal_res", 64'(last_res), 64'(32'hDEADBEEF));
        chk("illegal_fl", 64'(last_fl), 64'(4'b0000));
`endif

        // Randomised traffic.
        for (int s = 0; s < 600; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) == 0) begin
                    pend_a[i]  = $urandom;
                    pend_b[i]  = ($urandom_range(0, 3) == 0) ? pend_a[i] : $urandom;
                    pend_op[i] = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
                    pend_v[i]  = 1'b1;
                end else if (pend_v[i] && $urandom_range(0, 15) == 0) begin
                    pend_v[i] = 1'b0;
                end
            end
            rdy_drv = ($urandom_range(0, 9) < 7);
            step();
        end
        rdy_drv = 1'b1;
        pend_v = '0;
        wait_idle();
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
